// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES-128 encryption controller: one cipher round per clock with
// an on-the-fly key schedule and valid/ready handshakes on both sides.
// One block in flight; FSM IDLE -> ROUND (x10) -> DONE -> IDLE.
module aes_enc_round_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at byte offset 255-b from the LSB, i.e. ~b for an 8-bit b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [1:0]   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   round_cnt_q, round_cnt_d;
    logic [7:0]   rcon_q, rcon_d;

    logic [127:0] sb;      // SubBytes(state)
    logic [127:0] sr;      // ShiftRows(SubBytes(state))
    logic [127:0] mc;      // MixColumns(ShiftRows(SubBytes(state)))
    logic [127:0] nk;      // next round key
    logic [127:0] rnd;     // full round result
    logic [31:0]  sw;      // SubWord(RotWord(w3))
    logic [31:0]  kt;      // SubWord(RotWord(w3)) ^ Rcon

    genvar gi;

    // Sixteen state S-boxes.
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sub
            assign sb[8*gi +: 8] = sbox(state_q[8*gi +: 8]);
        end
    endgenerate

    // ShiftRows: byte (row r, col c) takes byte (row r, col (c+r) mod 4).
    generate
        for (gi = 0; gi < 16; gi++) begin : g_shift
            localparam int ROW = gi % 4;
            localparam int SRC = 4 * (((gi / 4) + ROW) % 4) + ROW;
            assign sr[8*gi +: 8] = sb[8*SRC +: 8];
        end
    endgenerate

    // MixColumns, one column per iteration.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = sr[32*gi +: 8];
            assign a1 = sr[32*gi + 8 +: 8];
            assign a2 = sr[32*gi + 16 +: 8];
            assign a3 = sr[32*gi + 24 +: 8];
            assign mc[32*gi +: 8]      = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
            assign mc[32*gi + 8 +: 8]  = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
            assign mc[32*gi + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
            assign mc[32*gi + 24 +: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        end
    endgenerate

    // Key schedule: four S-boxes on the rotated last word.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ksub
            assign sw[8*gi +: 8] = sbox(rk_q[96 + 8*((gi + 1) % 4) +: 8]);
        end
    endgenerate

    assign kt            = sw ^ {24'h000000, rcon_q};
    assign nk[31:0]      = rk_q[31:0]   ^ kt;
    assign nk[63:32]     = rk_q[63:32]  ^ nk[31:0];
    assign nk[95:64]     = rk_q[95:64]  ^ nk[63:32];
    assign nk[127:96]    = rk_q[127:96] ^ nk[95:64];

    // The final round skips MixColumns.
    assign rnd = ((round_cnt_q == 4'd10) ? sr : mc) ^ nk;

    // Next-state logic for the FSM, state, round key, counter and Rcon.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        rk_d        = rk_q;
        round_cnt_d = round_cnt_q;
        rcon_d      = rcon_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d     = in_data ^ in_key;
                    rk_d        = in_key;
                    round_cnt_d = 4'd1;
                    rcon_d      = 8'h01;
                    fsm_d       = ROUND;
                end
            end
            ROUND: begin
                state_d = rnd;
                rk_d    = nk;
                rcon_d  = xtime(rcon_q);
                if (round_cnt_q == 4'd10) begin
                    fsm_d = DONE;
                end else begin
                    round_cnt_d = round_cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d       = IDLE;
                    round_cnt_d = 4'd0;
                end
            end
            default: begin
                fsm_d       = IDLE;
                round_cnt_d = 4'd0;
            end
        endcase
    end

    // Register update with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            state_q     <= 128'h0;
            rk_q        <= 128'h0;
            round_cnt_q <= 4'd0;
            rcon_q      <= 8'h00;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            rk_q        <= rk_d;
            round_cnt_q <= round_cnt_d;
            rcon_q      <= rcon_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q != IDLE);
    assign out_data  = state_q;
    assign round_cnt = round_cnt_q;

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Self-checking bench for aes_enc_round_ctrl: known-answer table plus random
// vectors against a byte-array AES model, and hand-written corner sequences.
module tb_aes_enc_round_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [3:0]   round_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] tb_sbox [256];

    always #5 clk = ~clk;

    aes_enc_round_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round_cnt (round_cnt)
    );

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           stall;
    } vec_t;

    vec_t vecs [8];

    // FIPS byte string (byte 0 leftmost) -> bus layout (byte k at [8k+7:8k]).
    function automatic logic [127:0] fips2bus(input logic [127:0] f);
        logic [127:0] b;
        for (int k = 0; k < 16; k++) b[8*k +: 8] = f[127 - 8*k -: 8];
        return b;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                         ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Reference AES-128: state after 'upto' rounds (0 = initial AddRoundKey).
    function automatic logic [127:0] aes_model(input logic [127:0] key,
                                               input logic [127:0] pt,
                                               input int upto);
        logic [7:0] kb [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] rc;
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int k = 0; k < 16; k++) begin
            kb[k] = key[8*k +: 8];
            s[k]  = pt[8*k +: 8] ^ kb[k];
        end
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = kb[4*(i-1) + j];
            if (i % 4 == 0) begin
                tmp[0] = tb_sbox[kb[4*(i-1) + 1]] ^ rc;
                tmp[1] = tb_sbox[kb[4*(i-1) + 2]];
                tmp[2] = tb_sbox[kb[4*(i-1) + 3]];
                tmp[3] = tb_sbox[kb[4*(i-1) + 0]];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) kb[4*i + j] = kb[4*(i-4) + j] ^ tmp[j];
        end
        for (int r = 1; r <= upto; r++) begin
            for (int k = 0; k < 16; k++) s[k] = tb_sbox[s[k]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[4*c + w] = s[4*((c + w) % 4) + w];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ kb[16*r + k];
        end
        for (int k = 0; k < 16; k++) res[8*k +: 8] = s[k];
        return res;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one block and leave the bench 1 time unit after the accept edge.
    task automatic send(input logic [127:0] key, input logic [127:0] pt);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_in_ready", 128'(in_ready), 128'd1);
        in_key   = key;
        in_data  = pt;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // Full transaction with optional DONE stall; checks latency, result and return to IDLE.
    task automatic run_block(input string name, input logic [127:0] key,
                             input logic [127:0] pt, input logic [127:0] exp_ct,
                             input int stall);
        int cyc;
        out_ready = (stall == 0);
        send(key, pt);
        wait_done(cyc);
        check({name, "_latency"}, 128'(cyc), 128'd10);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check({name, "_ct"}, out_data, exp_ct);
        $display("block %s key=%h pt=%h ct=%h lat=%0d", name, key, pt, out_data, cyc);
        @(posedge clk); #1;
        check({name, "_idle"}, 128'({in_ready, out_valid, busy}), 128'b100);
    endtask

    // Per-round trace: round_cnt and intermediate state against the model.
    task automatic trace_block(input string name, input logic [127:0] key,
                               input logic [127:0] pt, input logic [127:0] exp_ct,
                               input logic [127:0] r1_exp, input logic chk_r1);
        out_ready = 1'b1;
        send(key, pt);
        check({name, "_rcnt0"}, 128'(round_cnt), 128'd1);
        check({name, "_state0"}, out_data, aes_model(key, pt, 0));
        for (int r = 1; r <= 9; r++) begin
            @(posedge clk); #1;
            check({name, "_rcnt"}, 128'(round_cnt), 128'(r + 1));
            check({name, "_busy"}, 128'({busy, out_valid, in_ready}), 128'b100);
            check({name, "_round_state"}, out_data, aes_model(key, pt, r));
            if (chk_r1 && r == 1) check({name, "_round1_fips"}, out_data, r1_exp);
        end
        @(posedge clk); #1;
        check({name, "_done_flags"}, 128'({out_valid, busy, round_cnt}), {122'd0, 2'b11, 4'd10});
        check({name, "_ct"}, out_data, exp_ct);
        $display("block %s traced ct=%h", name, out_data);
        @(posedge clk); #1;
        check({name, "_ready_after"}, 128'(in_ready), 128'd1);
    endtask

    logic [127:0] c1_key, c1_pt, c1_ct, c1_r1, z_ct;
    logic [127:0] snap_data, acc_out [2];
    logic [5:0]   snap_flags;
    logic         ready_seen, ov_seen, rdy;
    int           cyc, n_acc, n_out, acc_t [2];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_key = '0;
        build_sbox();
        c1_key = fips2bus(128'h000102030405060708090a0b0c0d0e0f);
        c1_pt  = fips2bus(128'h00112233445566778899aabbccddeeff);
        c1_ct  = fips2bus(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        c1_r1  = fips2bus(128'h89d810e8855ace682d1843d8cb128fe4);
        z_ct   = fips2bus(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", 128'({in_ready, out_valid, busy, round_cnt}), {121'd0, 3'b100, 4'd0});
        check("reset_data", out_data, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Round-by-round traces
        trace_block("c1_trace", c1_key, c1_pt, c1_ct, c1_r1, 1'b1);
        trace_block("zero_trace", 128'd0, 128'd0, z_ct, 128'd0, 1'b0);

        // Table of known-answer and random vectors
        vecs[0] = '{key: c1_key, pt: c1_pt, ct: c1_ct, stall: 0};
        vecs[1] = '{key: 128'd0, pt: 128'd0, ct: z_ct, stall: 2};
        for (int i = 2; i < 8; i++) begin
            vecs[i].key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            vecs[i].pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
            vecs[i].ct    = aes_model(vecs[i].key, vecs[i].pt, 10);
            vecs[i].stall = int'($urandom_range(0, 3));
        end
        for (int i = 0; i < 8; i++)
            run_block($sformatf("vec%0d", i), vecs[i].key, vecs[i].pt, vecs[i].ct, vecs[i].stall);

        // Backpressure: out_ready low for 5 cycles in DONE
        out_ready = 1'b0;
        send(c1_key, c1_pt);
        wait_done(cyc);
        check("bp_latency", 128'(cyc), 128'd10);
        snap_data  = out_data;
        snap_flags = {out_valid, busy, round_cnt};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_flags", 128'({out_valid, busy, round_cnt}), 128'(snap_flags));
            check("bp_hold_data", out_data, snap_data);
        end
        check("bp_ct", snap_data, c1_ct);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 128'({in_ready, out_valid, busy, round_cnt}), {121'd0, 3'b100, 4'd0});
        check("bp_keep_ct", out_data, c1_ct);
        $display("block backpressure ct=%h", snap_data);

        // Ignored in_valid during rounds 3..7
        send(c1_key, c1_pt);
        cyc = 0; ready_seen = 1'b0;
        while (!out_valid && cyc < 40) begin
            if (round_cnt >= 4'd3 && round_cnt <= 4'd7) begin
                in_valid = 1'b1;
                in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
                in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            end else begin
                in_valid = 1'b0;
            end
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("ign_in_ready", 128'(ready_seen), 128'd0);
        check("ign_latency", 128'(cyc), 128'd10);
        check("ign_ct", out_data, c1_ct);
        $display("block ignore-input ct=%h", out_data);
        @(posedge clk); #1;

        // Asynchronous reset abort at round_cnt = 5
        send(c1_key, c1_pt);
        cyc = 0;
        while (round_cnt != 4'd5 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_reach_r5", 128'(round_cnt), 128'd5);
        #2 rst_n = 1'b0;
        #1;
        check("abort_flags", 128'({in_ready, out_valid, busy, round_cnt}), {121'd0, 3'b100, 4'd0});
        check("abort_data", out_data, 128'd0);
        ov_seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            ov_seen = ov_seen | out_valid;
        end
        #2 rst_n = 1'b1;
        repeat (14) begin
            @(posedge clk); #1;
            ov_seen = ov_seen | out_valid;
        end
        check("abort_no_out_valid", 128'(ov_seen), 128'd0);
        check("abort_ready", 128'(in_ready), 128'd1);
        run_block("after_abort", c1_key, c1_pt, c1_ct, 0);

        // Back-to-back: in_valid held high, out_ready high
        out_ready = 1'b1;
        in_key = c1_key; in_data = c1_pt; in_valid = 1'b1;
        n_acc = 0; n_out = 0;
        for (int t = 0; t < 40 && n_out < 2; t++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy && in_valid && n_acc < 2) begin
                acc_t[n_acc] = t;
                n_acc++;
                if (n_acc == 1) begin
                    in_key = 128'd0; in_data = 128'd0;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid && n_out < 2) begin
                acc_out[n_out] = out_data;
                n_out++;
            end
        end
        in_valid = 1'b0;
        check("b2b_accepts", 128'(n_acc), 128'd2);
        check("b2b_outputs", 128'(n_out), 128'd2);
        if (n_acc == 2) check("b2b_spacing", 128'(acc_t[1] - acc_t[0]), 128'd12);
        if (n_out == 2) begin
            check("b2b_ct0", acc_out[0], c1_ct);
            check("b2b_ct1", acc_out[1], z_ct);
            $display("block b2b ct0=%h ct1=%h", acc_out[0], acc_out[1]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_enc_round_ctrl.md
# aes_enc_round_ctrl

Iterative AES-128 encryption controller that drives one cipher round per clock through the team's existing round datapath: SubBytes, the `shift_rows` permutation, MixColumns and AddRoundKey. It also drives an on-the-fly key schedule. A valid/ready handshake on each side connects it to the stream wrapper upstream and the output buffer downstream. It owns the state register, the round-key register, the round counter and the Rcon sequence. Exactly one block is in flight at a time.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- Clock and reset:
  - `clk` input 1: single clock, all state updates on the rising edge.
  - `rst_n` input 1: asynchronous, active-low reset.
- Input side:
  - `in_valid` input 1: `in_data`/`in_key` are valid.
  - `in_ready` output 1: the block can accept; high only in IDLE.
  - `in_data` input 128: plaintext.
  - `in_key` input 128: cipher key.
- Output side:
  - `out_valid` output 1: ciphertext is valid; high only in DONE.
  - `out_ready` input 1: the consumer accepts the ciphertext.
  - `out_data` output 128: ciphertext, driven directly from the state register.
- Status:
  - `busy` output 1: high in ROUND and DONE.
  - `round_cnt` output 4: current round number, 0 in IDLE.
- Byte order, common to all 128-bit buses: FIPS-197 byte k (k = 4·col + row) sits at bits [8k+7:8k]. This matches the datapath's existing column-major layout.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid` & `in_ready`: state ← `in_data` ^ `in_key`; rk ← `in_key`; `round_cnt` ← 1; go to ROUND.
- ROUND, one round per cycle:
  - Key schedule: nk = expand(rk, rcon[`round_cnt`]), computed as w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,00,00,00}, then w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - Rcon for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
  - Rounds 1–9: state ← MixColumns(ShiftRows(SubBytes(state))) ^ nk; rk ← nk; `round_cnt` increments.
  - Round 10: MixColumns is bypassed; state ← ShiftRows(SubBytes(state)) ^ nk; go to DONE.
- DONE:
  - `out_valid`=1; `out_data` and `round_cnt`=10 are held stable until `out_ready`=1.
  - On handshake: go to IDLE; `round_cnt` ← 0. The state register keeps the ciphertext until the next accept.
- `in_valid` outside IDLE is ignored and has no side effects. `in_data`/`in_key` are sampled only on the accept edge.
- `out_ready` outside DONE is ignored.
- Combinational hardware: 16 S-boxes for the state, 4 for the key schedule, one MixColumns instance and one `shift_rows` instance. No combinational path from any input to any output.

## Timing
- Reset (asynchronous, immediate):
  - FSM=IDLE.
  - `in_ready`=1, `out_valid`=0, `busy`=0, `round_cnt`=0.
  - `out_data`=0 (state register cleared), rk=0.
- Reset asserted mid-operation aborts the block: no `out_valid` pulse, and the block is ready again on the first edge after release.
- Latency: with the accept on edge E0, `out_valid` rises after edge E10, i.e. 10 cycles later.
- Throughput:
  - If `out_ready` is already high when `out_valid` rises, `in_ready` is high again after edge E11.
  - Minimum spacing between input accepts is 12 edges (E0, E12, …).
- `out_ready` low in DONE stalls indefinitely with outputs held. No output can be lost or overwritten.

## Test plan
- FIPS-197 C.1 vector: key bytes 00..0f, plaintext 00112233445566778899aabbccddeeff, `out_ready`=1 → `out_valid` 10 cycles after accept; ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a (FIPS byte order). Also check intermediate round 1 state 89d810e8855ace682d1843d8cb128fe4.
- All-zero key and plaintext → 66e94bd4ef8a2c3b884cfa59ca342b2e; `round_cnt` reads 1..10 across the rounds.
- Backpressure: `out_ready` held low for 5 cycles in DONE → `out_valid`, `out_data` and `busy` stay constant; handshake on cycle 6; `in_ready` high the next cycle.
- Ignored input: pulse `in_valid` with different data during rounds 3–7 → result is unchanged from the first vector, and `in_ready` stays 0 throughout.
- Reset abort: assert `rst_n`=0 asynchronously at `round_cnt`=5 → all outputs take their reset values immediately and no `out_valid` appears. A new C.1 block issued after release produces the correct ciphertext.
- Back-to-back: two blocks (C.1, then all-zero), with `in_valid` held high and `out_ready`=1 → accepts land on E0 and E12; outputs appear in order with correct values.
